cond_flag_unit: RTL

Consumer end of the ALU flag interface. Holds the architectural NZCV flags, accepts flag updates produced by flag-setting ALU ops, and evaluates the 4-bit ARM condition field of each issued instruction against them. Sits between decode and execute. Emits a registered execute/squash decision per instruction through a valid/ready pipeline stage. Keeps saturating executed/squashed counters for debug.

---
 rtl/cond_flag_unit_pkg.sv | 58 +++++
 rtl/cond_flag_unit_eval.sv | 13 +
 rtl/cond_flag_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cond_flag_unit_pkg.sv
// cond_pkg: shared definitions for the condition/flag unit.
// Holds the ARM condition-code encodings, NZCV bit positions and the
// condition-pass function used by the evaluator.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Returns 1 when the instruction with condition 'cond' executes under 'nzcv'.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            COND_NV: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cond_flag_unit_eval.sv
// cond_eval: combinational condition evaluator, a thin wrapper around
// cond_pass so the truth table can be exercised as a standalone unit.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    assign pass = cond_pass(cond, nzcv);

endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: architectural NZCV flag holder plus a one-entry
// valid/ready stage that turns each issued condition field into a
// registered execute/squash decision, with saturating debug counters.
// Optional build macro COND_FLAG_Q_EN adds a sticky saturation flag
// (q_set/q_clr/q_flag) raised when either counter tries to pass all-ones.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_we,
    input  logic [3:0]       flag_mask,
    input  logic [3:0]       flag_nzcv,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [3:0]       ins_cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_exec,
    output logic [3:0]       out_cond,
    output logic [3:0]       nzcv,
`ifdef COND_FLAG_Q_EN
    input  logic             q_set,
    input  logic             q_clr,
    output logic             q_flag,
`endif
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       nzcv_r;
    logic [3:0]       eff_s;
    logic             pass_s;
    logic             out_valid_r;
    logic             out_exec_r;
    logic [3:0]       out_cond_r;
    logic [CNT_W-1:0] exec_cnt_r;
    logic [CNT_W-1:0] squash_cnt_r;
    logic             ins_ready_s;
    logic             accept_s;
    logic             hs_s;
    logic             exec_inc_s;
    logic             squash_inc_s;
    logic             exec_sat_s;
    logic             squash_sat_s;

    // Effective flags: a same-cycle ALU update bypasses into evaluation.
    always_comb begin
        eff_s = nzcv_r;
        if (flag_we) begin
            eff_s = (nzcv_r & ~flag_mask) | (flag_nzcv & flag_mask);
        end else begin
            eff_s = nzcv_r;
        end
    end

    cond_eval u_cond_eval (
        .cond (ins_cond),
        .nzcv (eff_s),
        .pass (pass_s)
    );

    assign ins_ready_s  = ~out_valid_r | out_ready;
    assign accept_s     = ins_valid & ins_ready_s;
    assign hs_s         = out_valid_r & out_ready;
    assign exec_inc_s   = hs_s & out_exec_r;
    assign squash_inc_s = hs_s & ~out_exec_r;
    assign exec_sat_s   = (exec_cnt_r == CNT_MAX);
    assign squash_sat_s = (squash_cnt_r == CNT_MAX);

    // Architectural flag register; eff_s already equals nzcv_r when no update.
    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv_r <= 4'b0000;
        end else begin
            nzcv_r <= eff_s;
        end
    end

    // One-entry decision stage: load on accept, drain on handshake, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_exec_r  <= 1'b0;
            out_cond_r  <= 4'b0000;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_exec_r  <= pass_s;
            out_cond_r  <= ins_cond;
        end else if (hs_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Executed-decision counter, counted on output handshake, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_cnt_r <= {CNT_W{1'b0}};
        end else if (exec_inc_s && !exec_sat_s) begin
            exec_cnt_r <= exec_cnt_r + CNT_ONE;
        end else begin
            exec_cnt_r <= exec_cnt_r;
        end
    end

    // Squashed-decision counter, counted on output handshake, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            squash_cnt_r <= {CNT_W{1'b0}};
        end else if (squash_inc_s && !squash_sat_s) begin
            squash_cnt_r <= squash_cnt_r + CNT_ONE;
        end else begin
            squash_cnt_r <= squash_cnt_r;
        end
    end

`ifdef COND_FLAG_Q_EN
    logic q_flag_r;
    logic q_ovf_s;

    assign q_ovf_s = (exec_inc_s & exec_sat_s) | (squash_inc_s & squash_sat_s);

    // Sticky saturation flag: overflow or q_set set it, and set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_flag_r <= 1'b0;
        end else if (q_set || q_ovf_s) begin
            q_flag_r <= 1'b1;
        end else if (q_clr) begin
            q_flag_r <= 1'b0;
        end else begin
            q_flag_r <= q_flag_r;
        end
    end

    assign q_flag = q_flag_r;
`endif

    assign ins_ready  = ins_ready_s;
    assign out_valid  = out_valid_r;
    assign out_exec   = out_exec_r;
    assign out_cond   = out_cond_r;
    assign nzcv       = nzcv_r;
    assign exec_cnt   = exec_cnt_r;
    assign squash_cnt = squash_cnt_r;

endmodule
